// File: rtl/stoch_pkg.sv
// Shared types and width helpers for the stochastic max-pool channel scheduler.
package stoch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_CHANNELS   = 256;
    localparam int DEF_STREAM_LEN = 256;

    // Never returns 0 so single-value ranges still get a 1-bit vector.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_W   = width_for(DEF_CHANNELS);
    localparam int BEAT_W = width_for(DEF_STREAM_LEN + 1);

    typedef struct packed {
        state_t      state;
        logic [15:0] beat;
        logic [15:0] clr;
    } dbg_t;

endpackage

// File: rtl/stoch_maxpool_sched_if.sv
// Control bundle between upstream source, scheduler and pool/capture logic.
interface stoch_maxpool_sched_if #(
    parameter int CH_W = stoch_pkg::CH_W
);
    import stoch_pkg::*;

    // Upstream bit is consumed exactly on cycles where x_valid && x_ready.
    logic            start;
    logic            x_valid;
    logic            x_ready;
    logic [CH_W-1:0] ch_sel;
    logic            pool_clr;
    logic            pool_en;
    logic            y_valid;
    logic            busy;
    logic            done;
    dbg_t            dbg;

    modport master (
        output start, x_valid,
        input  x_ready, ch_sel, pool_clr, pool_en, y_valid, busy, done, dbg
    );

    modport slave (
        input  start, x_valid,
        output x_ready, ch_sel, pool_clr, pool_en, y_valid, busy, done, dbg
    );

endinterface

// File: rtl/stoch_beat_counter.sv
// Up-counter with synchronous clear (priority) and a terminal-count flag at LIMIT-1.
module stoch_beat_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == W'(LIMIT - 1));

endmodule

// File: rtl/stoch_maxpool_sched.sv
// Channel sequencer for a shared stochastic max-pool array: CLEAR then RUN per channel.
// Optional macro STOCH_MAXPOOL_WARMUP_EN masks y_valid for the first WARMUP beats.
module stoch_maxpool_sched
    import stoch_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int STREAM_LEN = DEF_STREAM_LEN,
    parameter int CLR_CYCLES = 2,
    parameter int WARMUP     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    stoch_maxpool_sched_if.slave bus
);

    localparam int CW_CH = width_for(CHANNELS);
    localparam int CW_BT = width_for(STREAM_LEN + 1);
    localparam int CW_CL = width_for(CLR_CYCLES + 1);

    if (CLR_CYCLES < 1 || WARMUP >= STREAM_LEN) begin : g_bad_cfg
        $error("stoch_maxpool_sched: need CLR_CYCLES >= 1 and WARMUP < STREAM_LEN");
    end

    state_t             state;
    state_t             state_nx;
    logic [CW_CH-1:0]   ch_q;
    logic [CW_BT-1:0]   beat_cnt;
    logic [CW_CL-1:0]   clr_cnt;
    logic               beat_tc;
    logic               clr_tc;
    logic               beat;
    logic               last_beat;
    logic               last_ch;
    logic               warm_ok;
    logic               x_ready_c;
    logic               pool_clr_c;
    logic               pool_en_c;
    logic               busy_c;
    logic               done_c;

    assign beat      = (state == RUN) && bus.x_valid;
    assign last_beat = beat && beat_tc;
    assign last_ch   = (ch_q == CW_CH'(CHANNELS - 1));

    // Cleared on the final beat so the count is already zero when CLEAR begins.
    stoch_beat_counter #(.W(CW_BT), .LIMIT(STREAM_LEN)) u_beat_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (last_beat || (state != RUN)),
        .en    (beat),
        .count (beat_cnt),
        .tc    (beat_tc)
    );

    stoch_beat_counter #(.W(CW_CL), .LIMIT(CLR_CYCLES)) u_clr_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (state != CLEAR),
        .en    (state == CLEAR),
        .count (clr_cnt),
        .tc    (clr_tc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = CLEAR;
            CLEAR:   if (clr_tc) state_nx = RUN;
            RUN:     if (last_beat) state_nx = last_ch ? DONE : CLEAR;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        x_ready_c  = 1'b0;
        pool_clr_c = 1'b0;
        pool_en_c  = 1'b0;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                pool_clr_c = 1'b1;
                busy_c     = 1'b0;
            end
            CLEAR: pool_clr_c = 1'b1;
            RUN: begin
                x_ready_c = 1'b1;
                pool_en_c = bus.x_valid;
            end
            DONE:    done_c = 1'b1;
            default: busy_c = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ch_q <= '0;
        end else if (state == DONE) begin
            ch_q <= '0;
        end else if (last_beat && !last_ch) begin
            ch_q <= ch_q + 1'b1;
        end
    end

`ifdef STOCH_MAXPOOL_WARMUP_EN
    assign warm_ok = (beat_cnt >= CW_BT'(WARMUP));
`else
    assign warm_ok = 1'b1;
`endif

    assign bus.x_ready   = x_ready_c;
    assign bus.pool_clr  = pool_clr_c;
    assign bus.pool_en   = pool_en_c;
    assign bus.y_valid   = pool_en_c && warm_ok;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.ch_sel    = ch_q;
    assign bus.dbg.state = state;
    assign bus.dbg.beat  = 16'(beat_cnt);
    assign bus.dbg.clr   = 16'(clr_cnt);

endmodule
